memory_gateway_arbiter: RTL
===========================

# memory_gateway_arbiter

Round-robin arbiter that shares one `memory_gateway` (HLS-style ap_start/ap_done handshake, single outstanding access) among `NUM_PORTS` requesters such as the core array and the host-side debug path. It latches one request at a time and drives the gateway's start/addr/wdata/wen. It routes `ap_return` back to the granted requester as a one-cycle response pulse. A watchdog flags a gateway that never completes.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..16.
- `ADDR_WIDTH`, 64: address width, matching the gateway `addr`.
- `DATA_WIDTH`, 16: data width, matching the gateway `wdata`/`ap_return`.
- `TIMEOUT`, 1024: maximum cycles in `Issue` before the watchdog fires; must be at least 2.
- `clock`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_PORTS  per-port request; held with stable payload until that port's `resp_valid`.
- `req_wen`  in  NUM_PORTS  per-port write flag.
- `req_addr`  in  NUM_PORTS*ADDR_WIDTH  flattened; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  NUM_PORTS*DATA_WIDTH  flattened, same packing.
- `resp_valid`  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- `resp_data`  out  DATA_WIDTH  read data, valid while any `resp_valid` bit is high; 0 for writes.
- `gw_ap_start`  out  1  gateway start.
- `gw_addr`  out  ADDR_WIDTH  gateway address.
- `gw_wdata`  out  DATA_WIDTH  gateway write data.
- `gw_wen`  out  1  gateway write enable.
- `gw_ap_done`  in  1  gateway completion.
- `gw_ap_return`  in  DATA_WIDTH  gateway read data, valid while `gw_ap_done` is high.
- `busy`  out  1  high in every state except `Idle`.
- `timeout_error`  out  1  sticky watchdog flag.

## Operation
- States and transitions:
  - `Idle` → `Issue` when any `req_valid` is high.
  - `Issue` → `Respond` on `gw_ap_done`.
  - `Issue` → `Halt` when the watchdog count reaches `TIMEOUT-1` without `gw_ap_done`.
  - `Respond` → `Idle` unconditionally.
  - `Halt` is left only by `reset`.
- Arbitration happens in `Idle` only. The winner is the lowest index at or above `rr_ptr` with `req_valid` high, searching cyclically.
  - On the `Idle`→`Issue` edge, latch into registers: grant index, addr, wdata, wen.
  - `rr_ptr` becomes (grant+1) mod NUM_PORTS on the `Respond` cycle; wrap from NUM_PORTS-1 to 0.
- Gateway drive:
  - `gw_ap_start = (state==Issue)` (combinational from the state register).
  - `gw_addr`, `gw_wdata`, `gw_wen` come from the latched registers and are stable for the whole of `Issue`.
  - Requester inputs never reach the gateway combinationally.
- Completion:
  - Capture `gw_ap_return` into `rdata_reg` on the `gw_ap_done` cycle; capture 0 when the latched wen=1.
  - In `Respond`: `resp_valid[grant]=1` and `resp_data=rdata_reg`.
- Watchdog:
  - Counter clears on entry to `Issue` and increments every `Issue` cycle.
  - On firing: set `timeout_error`, pulse `resp_valid[grant]` with `resp_data=0` in the same cycle, enter `Halt`.
  - In `Halt`: `gw_ap_start=0`, no further grants, `busy=1`.
- Requester changes while granted are ignored: payload is latched, and a dropped `req_valid` does not abort the access.
- A requester that holds `req_valid` after its response is treated as a new request.

## Timing
- Reset values:
  - state `Idle`, `rr_ptr`=0, `resp_valid`=0, `resp_data`=0.
  - `gw_ap_start`=0, `gw_wen`=0, `gw_addr`=0, `gw_wdata`=0.
  - `busy`=0, `timeout_error`=0, watchdog count 0.
- `reset` during `Issue` drops `gw_ap_start` the next cycle. The in-flight access produces no response, and a pending gateway write may still commit. The gateway shares `reset` and must be reset together with the arbiter.
- Latency, with `req_valid` first seen in cycle t in `Idle`:
  - `gw_ap_start` is high from t+1.
  - With gateway latency L, `gw_ap_done` arrives at t+L+2.
  - `resp_valid` is at t+L+3, which is t+7 for L=4.
  - The next grant is decided at t+L+4.
- `gw_ap_start` is low in the cycle after `gw_ap_done`, so the gateway sees no spurious restart when it returns to idle.
- Throughput: one access per L+4 cycles.
- Simultaneous requests are served strictly round-robin; no port waits more than NUM_PORTS-1 grants.

## Test plan
- Single read, port 2, addr 0x10, memory preloaded 0xBEEF, L=4: `resp_valid`=4'b0100 at t+7 with `resp_data`=0xBEEF; `gw_ap_start` high t+1..t+6 exactly.
- Write then read, port 0: write 0x1234 to addr 5, then read addr 5 → two responses, the second with `resp_data`=0x1234, the write response with `resp_data`=0.
- All four ports request continuously from reset: grant order 0,1,2,3,0,1; each `resp_valid` is one cycle; no port is served twice before the others.
- `rr_ptr` wrap: after a grant to port 3, ports 0 and 3 both requesting → port 0 wins.
- Stalled gateway (`gw_ap_done` tied low), TIMEOUT=8: response with data 0 on the 8th `Issue` cycle, `timeout_error` rises and stays high; later requests are never granted until `reset`.
- `reset` asserted mid-`Issue`: next cycle `gw_ap_start`=0, `busy`=0, no `resp_valid`; after release a fresh read completes normally.

Source files
------------

// File: rtl/memory_gateway_arbiter_if.sv
// Requester-side and gateway-side signals of the memory gateway arbiter.
// The master modport is the arbiter's view. The slave modport is the environment's view (requesters plus gateway).
interface memory_gateway_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_wen;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]           resp_data;
    logic                            gw_ap_start;
    logic [ADDR_WIDTH-1:0]           gw_addr;
    logic [DATA_WIDTH-1:0]           gw_wdata;
    logic                            gw_wen;
    logic                            gw_ap_done;
    logic [DATA_WIDTH-1:0]           gw_ap_return;
    logic                            busy;
    logic                            timeout_error;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, gw_ap_done, gw_ap_return,
        output resp_valid, resp_data, gw_ap_start, gw_addr, gw_wdata, gw_wen,
               busy, timeout_error
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, gw_ap_done, gw_ap_return,
        input  resp_valid, resp_data, gw_ap_start, gw_addr, gw_wdata, gw_wen,
               busy, timeout_error
    );
endinterface

// File: rtl/memory_gateway_arbiter.sv
// Round-robin arbiter sharing one single-outstanding ap_start/ap_done memory gateway
// among NUM_PORTS requesters, with a sticky watchdog on stalled accesses.
module memory_gateway_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    memory_gateway_arbiter_if.master  bus
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESPOND, ST_HALT} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
    logic                  timeout_error_q, timeout_error_d;

    logic                  arb_found;
    logic [IDX_W-1:0]      arb_idx;
    logic                  wd_fire;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return IDX_W'(s);
    endfunction

    // Cyclic search for the first requester at or above rr_ptr.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!arb_found && bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
                arb_found = 1'b1;
                arb_idx   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    assign wd_fire = (state_q == ST_ISSUE) && !bus.gw_ap_done &&
                     (wd_cnt_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wen_d           = wen_q;
        rdata_d         = rdata_q;
        wd_cnt_d        = wd_cnt_q;
        timeout_error_d = timeout_error_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d  = ST_ISSUE;
                    grant_d  = arb_idx;
                    addr_d   = bus.req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d  = bus.req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                    wen_d    = bus.req_wen[arb_idx];
                    wd_cnt_d = '0;
                end
            end
            ST_ISSUE: begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
                if (bus.gw_ap_done) begin
                    state_d = ST_RESPOND;
                    rdata_d = wen_q ? '0 : bus.gw_ap_return;
                end else if (wd_fire) begin
                    state_d         = ST_HALT;
                    timeout_error_d = 1'b1;
                end
            end
            ST_RESPOND: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= '0;
            grant_q         <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wen_q           <= 1'b0;
            rdata_q         <= '0;
            wd_cnt_q        <= '0;
            timeout_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_q         <= grant_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wen_q           <= wen_d;
            rdata_q         <= rdata_d;
            wd_cnt_q        <= wd_cnt_d;
            timeout_error_q <= timeout_error_d;
        end
    end

    // Gateway and response outputs come only from registers (plus the watchdog pulse).
    assign bus.gw_ap_start   = (state_q == ST_ISSUE);
    assign bus.gw_addr       = addr_q;
    assign bus.gw_wdata      = wdata_q;
    assign bus.gw_wen        = wen_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.timeout_error = timeout_error_q;
    assign bus.resp_valid    = ((state_q == ST_RESPOND) || wd_fire) ?
                               (NUM_PORTS'(1) << grant_q) : '0;
    assign bus.resp_data     = (state_q == ST_RESPOND) ? rdata_q : '0;

endmodule
